// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity helper and parameter defaults.
// Used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int DEFAULT_BAUD_DIV  = 434;
    localparam int DEFAULT_DATA_BITS = 8;
    localparam int MAX_DATA_BITS     = 9;

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [MAX_DATA_BITS-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter. It runs 0..BAUD_DIV-1 and strobes bit_end_o on the last count.
// While clr_i is high, the count is held at zero.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic bit_end_o
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        bit_end_o = (cnt_q == LAST);
        if (clr_i || bit_end_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter. It sends a start bit, then DATA_BITS data bits LSB first,
// then an optional even-parity bit, then one stop bit. All outputs come from flops.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV      = DEFAULT_BAUD_DIV,
    parameter int DATA_BITS     = DEFAULT_DATA_BITS,
    parameter int ENABLE_PARITY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 done
);

    localparam int IW = $clog2(DATA_BITS) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [IW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;
    logic                 bit_end;

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (state_q == IDLE),
        .bit_end_o (bit_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d   = START;
                    bit_idx_d = '0;
                    shift_d   = tx_data;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = (ENABLE_PARITY != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The line value is decoded from the next state so that tx itself is a flop output.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:  tx_d = 1'b0;
            DATA: begin
                for (int i = 0; i < DATA_BITS; i++) begin
                    if (bit_idx_d == IW'(i)) tx_d = shift_q[i];
                end
            end
            PARITY: tx_d = even_parity(MAX_DATA_BITS'(shift_q));
            default: tx_d = 1'b1;
        endcase
        ready_d = (state_d == IDLE);
        done_d  = (state_q == STOP) && (state_d == IDLE);
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign done     = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at BAUD_DIV=4, DATA_BITS=8. It runs one instance without parity and one with parity.
// Every output is checked cycle by cycle against a hand-built frame.
module tb_uart_tx;

    localparam int BD = 4;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_a = 1'b0, valid_b = 1'b0;
    logic [DB-1:0] data_a = '0, data_b = '0;
    logic          ready_a, ready_b, tx_a, tx_b, done_a, done_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx #(.BAUD_DIV(BD), .DATA_BITS(DB), .ENABLE_PARITY(0)) u_dut_np (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_valid (valid_a),
        .tx_data  (data_a),
        .tx_ready (ready_a),
        .tx       (tx_a),
        .done     (done_a)
    );

    uart_tx #(.BAUD_DIV(BD), .DATA_BITS(DB), .ENABLE_PARITY(1)) u_dut_p (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_valid (valid_b),
        .tx_data  (data_b),
        .tx_ready (ready_b),
        .tx       (tx_b),
        .done     (done_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic get_tx(input bit par);
        return par ? tx_b : tx_a;
    endfunction

    function automatic logic get_ready(input bit par);
        return par ? ready_b : ready_a;
    endfunction

    function automatic logic get_done(input bit par);
        return par ? done_b : done_a;
    endfunction

    task automatic drive(input bit par, input logic v, input logic [DB-1:0] d);
        if (par) begin
            valid_b = v;
            data_b  = d;
        end else begin
            valid_a = v;
            data_a  = d;
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_tx"},    32'(tx_a),    32'd1);
        check_eq({tag, "_ready"}, 32'(ready_a), 32'd1);
        check_eq({tag, "_done"},  32'(done_a),  32'd0);
        check_eq({tag, "_tx_p"},    32'(tx_b),    32'd1);
        check_eq({tag, "_ready_p"}, 32'(ready_b), 32'd1);
        check_eq({tag, "_done_p"},  32'(done_b),  32'd0);
    endtask

    // Present a word before the next rising edge and return right after the accepting edge.
    task automatic begin_frame(input bit par, input logic [DB-1:0] d);
        @(negedge clk);
        drive(par, 1'b1, d);
        check_eq("ready_before_accept", 32'(get_ready(par)), 32'd1);
        @(posedge clk);
    endtask

    // Check every cycle of a frame that was accepted on the edge just passed.
    // At cycle 0, tx_data changes to d_after and tx_valid is set to hold.
    task automatic check_frame(input bit par, input logic [DB-1:0] d, input logic exp_par,
                               input logic [DB-1:0] d_after, input bit pulse_busy, input bit hold);
        int  f;
        int  slot;
        logic exp_tx;
        f = (2 + DB + (par ? 1 : 0)) * BD;
        for (int k = 0; k < f; k++) begin
            @(negedge clk);
            if (k == 0) drive(par, hold, d_after);
            if (pulse_busy && k == 12) drive(par, 1'b1, 8'hAA);
            if (pulse_busy && k == 14) drive(par, 1'b0, d_after);
            slot = k / BD;
            if (slot == 0)                   exp_tx = 1'b0;
            else if (slot <= DB)             exp_tx = d[slot-1];
            else if (par && slot == DB + 1)  exp_tx = exp_par;
            else                             exp_tx = 1'b1;
            check_eq($sformatf("tx_p%0d_%02h_c%0d", par, d, k), 32'(get_tx(par)), 32'(exp_tx));
            check_eq($sformatf("ready_p%0d_%02h_c%0d", par, d, k), 32'(get_ready(par)), 32'd0);
            check_eq($sformatf("done_p%0d_%02h_c%0d", par, d, k), 32'(get_done(par)), 32'd0);
        end
        @(negedge clk);
        check_eq($sformatf("end_done_p%0d_%02h", par, d), 32'(get_done(par)), 32'd1);
        check_eq($sformatf("end_ready_p%0d_%02h", par, d), 32'(get_ready(par)), 32'd1);
        check_eq($sformatf("end_tx_p%0d_%02h", par, d), 32'(get_tx(par)), 32'd1);
        if (!hold) begin
            @(negedge clk);
            check_eq($sformatf("done_clear_p%0d_%02h", par, d), 32'(get_done(par)), 32'd0);
        end
        $display("frame parity_en=%0d data=%02h length=%0d checked", par, d, f);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state, and quiet idle after release
        #12;
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check_idle($sformatf("idle_c%0d", i));
        end
        $display("reset and idle checked");

        // No parity: 0x55
        begin_frame(1'b0, 8'h55);
        check_frame(1'b0, 8'h55, 1'b0, 8'h55, 1'b0, 1'b0);

        // Parity: 0x07 has three ones and gives parity 1. 0x03 has two ones and gives parity 0. tx_data is changed after acceptance.
        begin_frame(1'b1, 8'h07);
        check_frame(1'b1, 8'h07, 1'b1, 8'hFF, 1'b0, 1'b0);
        begin_frame(1'b1, 8'h03);
        check_frame(1'b1, 8'h03, 1'b0, 8'h00, 1'b0, 1'b0);

        // Busy: a 0xAA pulse in the middle of the 0x0F frame must be ignored
        begin_frame(1'b0, 8'h0F);
        check_frame(1'b0, 8'h0F, 1'b0, 8'h0F, 1'b1, 1'b0);
        @(negedge clk);
        check_eq("busy_no_queue_ready", 32'(ready_a), 32'd1);
        check_eq("busy_no_queue_tx", 32'(tx_a), 32'd1);

        // Back to back: 0x01, then 0x80 with its start bit on the edge 41 cycles after the first
        begin_frame(1'b0, 8'h01);
        check_frame(1'b0, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        check_frame(1'b0, 8'h80, 1'b0, 8'h80, 1'b0, 1'b0);

        // Reset in the middle of data bit 3 (0xF0 puts a 0 on the line there)
        begin_frame(1'b0, 8'hF0);
        for (int k = 0; k <= 17; k++) begin
            @(negedge clk);
            if (k == 0) drive(1'b0, 1'b0, 8'hF0);
        end
        check_eq("bit3_before_reset", 32'(tx_a), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check_eq("async_reset_tx", 32'(tx_a), 32'd1);
        check_eq("async_reset_ready", 32'(ready_a), 32'd1);
        check_eq("async_reset_done", 32'(done_a), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("after_reset");
        $display("mid-frame reset checked");
        begin_frame(1'b0, 8'h3C);
        check_frame(1'b0, 8'h3C, 1'b0, 8'h3C, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
